// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the handshake CDC arbiter.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_HI,
    HS_WAIT_LO,
    HS_DRAIN
  } hs_state_e;

  // Widest requester vector rr_pick can search; NUM_REQ must not exceed it.
  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] searching upward from ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned       ptr,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n && !r.found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j[RR_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_2ff_sync.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
module cdc_2ff_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture; reset clears both stages so a stale input reads as 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack crossing among NUM_REQ requesters.
module cdc_hs_arbiter
  import cdc_hs_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err_timeout,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       xreq,
  output logic [DATA_W-1:0]          xdata,
  input  logic                       xack_async
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit          TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  hs_state_e         state;
  logic [ID_W-1:0]   rr_ptr;
  logic [TMR_W-1:0]  timer;
  logic              ack_s;
  rr_pick_t          pick;
  logic [ID_W-1:0]   win_id;
  logic              accept;
  logic              ack_done;
  logic              tmo_hit;
  logic              unused_pick_idx;

  cdc_2ff_sync #(.W(1)) u_ack_sync (
    .clk   (clk),
    .rst_n (~rst),
    .d     (xack_async),
    .q     (ack_s)
  );

  // Winner selection and the single-cycle event decodes.
  always_comb begin
    pick     = rr_pick(RR_MAX'(req_valid), 32'(rr_ptr), NUM_REQ);
    win_id   = pick.idx[ID_W-1:0];
    accept   = !rst && (state == HS_IDLE) && pick.found && !ack_s;
    ack_done = !rst && (state == HS_WAIT_LO) && !ack_s;
    tmo_hit  = TMO_EN && !rst && (state == HS_WAIT_HI) && !ack_s && (timer == TMO_LAST);
  end

  assign unused_pick_idx = ^pick.idx;

  // One-hot pulses for accept and completion, plus status.
  always_comb begin
    req_ready = '0;
    done      = '0;
    if (accept)   req_ready[win_id] = 1'b1;
    if (ack_done) done[grant_id]    = 1'b1;
    err_timeout = tmo_hit;
    busy        = (state != HS_IDLE);
  end

  // Handshake sequencer with payload, grant, RR pointer and timeout timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HS_IDLE;
      rr_ptr   <= '0;
      xreq     <= 1'b0;
      xdata    <= '0;
      grant_id <= '0;
      timer    <= '0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (accept) begin
            xdata    <= req_data[32'(win_id) * DATA_W +: DATA_W];
            grant_id <= win_id;
            xreq     <= 1'b1;
            rr_ptr   <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            timer    <= '0;
            state    <= HS_WAIT_HI;
          end
        end
        HS_WAIT_HI: begin
          if (timer != '1) timer <= timer + TMR_W'(1);
          // An ack landing on the timeout cycle takes priority over the abort.
          if (ack_s) begin
            xreq  <= 1'b0;
            state <= HS_WAIT_LO;
          end else if (tmo_hit) begin
            xreq  <= 1'b0;
            state <= HS_DRAIN;
          end
        end
        HS_WAIT_LO: begin
          if (!ack_s) state <= HS_IDLE;
        end
        HS_DRAIN: begin
          if (!ack_s) state <= HS_IDLE;
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule
